gen_nonlinear_part_seq: RTL and testbench

Iterative generator for the non-linear (AND-monomial) terms of the decomposed CLA. It produces the `n` vector consumed by the adder's linear XOR-reduction stage. Operands are accepted by a valid/ready handshake. One carry level is expanded per clock, and the completed `n` vector is presented, together with the registered operands, by an output valid/ready handshake.

---
 rtl/gen_nonlinear_part_seq.sv | 92 +++++++++
 tb/tb_gen_nonlinear_part_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_nonlinear_part_seq.sv
// gen_nonlinear_part_seq: iterative generator of the CLA non-linear monomial terms, one carry level per clock
module gen_nonlinear_part_seq #(
  parameter int NBIT = 7,
  localparam int NNL = 2**(NBIT+2)-NBIT-4,
  localparam int LW = 2**(NBIT+1)-1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NNL-1:0]  n,
  output logic [NBIT-1:0] a_o,
  output logic [NBIT-1:0] b_o,
  output logic            c_o
);
  localparam int KW = $clog2(NBIT+1);
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [LW-1:0] w_q, w_d, nxt;
  logic [NNL-1:0] n_q, n_d, ext;
  logic [NBIT-1:0] a_q, a_d, b_q, b_d;
  logic c_q, c_d, rdy_q;
  logic [31:0] kk, off;
  logic ak, bk;
  // L_{k+1} = [a&b] ++ a&L_k ++ b&L_k; the b-copy starts at |L_k|+1 = 2^(k+1)
  always_comb begin
    kk = 32'(k_q);
    off = (32'd1 << (kk + 32'd2)) - kk - 32'd4;
    ak = |(a_q & (NBIT'(1) << k_q));
    bk = |(b_q & (NBIT'(1) << k_q));
    nxt = ((w_q & {LW{ak}}) << 1) | ((w_q & {LW{bk}}) << (32'd1 << (kk + 32'd1)));
    nxt[0] = ak & bk;
    ext = '0;
    ext[LW-1:0] = nxt;
    state_d = state_q;
    k_d = k_q;
    w_d = w_q;
    n_d = n_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (state_q == IDLE && in_valid && rdy_q) begin
      state_d = GEN;
      a_d = a;
      b_d = b;
      c_d = c_in;
      w_d = LW'(c_in);
      n_d = '0;
      k_d = '0;
    end else if (state_q == GEN) begin
      w_d = nxt;
      n_d = n_q | (ext << off);
      k_d = k_q + 1'b1;
      state_d = (k_q == KW'(NBIT-1)) ? DONE : GEN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      w_q <= '0;
      n_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      w_q <= w_d;
      n_q <= n_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      rdy_q <= (state_d == IDLE);
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = (state_q == DONE);
  assign n = n_q;
  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;
endmodule

// File: tb/tb_gen_nonlinear_part_seq.sv
// tb_gen_nonlinear_part_seq: randomized self-checking bench against a list-based monomial model
module tb_gen_nonlinear_part_seq;
  logic clk = 1'b0;
  logic rst;
  logic iv, ir, ov, ordy, ci, co;
  logic [6:0] a, b, ao, bo;
  logic [500:0] n;
  logic iv2, ir2, ov2, or2, c2, co2;
  logic [1:0] a2, b2, ao2, bo2;
  logic [9:0] n2;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gen_nonlinear_part_seq #(.NBIT(7)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .c_in(ci),
    .out_valid(ov), .out_ready(ordy), .n(n), .a_o(ao), .b_o(bo), .c_o(co)
  );

  gen_nonlinear_part_seq #(.NBIT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .c_in(c2),
    .out_valid(ov2), .out_ready(or2), .n(n2), .a_o(ao2), .b_o(bo2), .c_o(co2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Builds every L_k as an explicit bit list and packs them one after another.
  function automatic logic [500:0] ref_n(logic [6:0] ra, logic [6:0] rb, logic rc);
    bit cur[$];
    bit nxt[$];
    int off;
    logic [500:0] r;
    r = '0;
    off = 0;
    cur.push_back(rc);
    for (int k = 0; k < 7; k++) begin
      nxt.delete();
      nxt.push_back(ra[k] & rb[k]);
      foreach (cur[i]) nxt.push_back(ra[k] & cur[i]);
      foreach (cur[i]) nxt.push_back(rb[k] & cur[i]);
      foreach (nxt[j]) r[off+j] = nxt[j];
      off += nxt.size();
      cur = nxt;
    end
    return r;
  endfunction

  // Linear part: carries are XOR-reductions of each list, sum bits are a^b^carry.
  function automatic logic [7:0] lin_s(int nb, logic [6:0] la, logic [6:0] lb, logic lc, logic [500:0] ln);
    logic [7:0] cy;
    logic [7:0] s;
    int off;
    int len;
    logic x;
    cy = '0;
    cy[0] = lc;
    off = 0;
    for (int k = 1; k <= nb; k++) begin
      len = (1 << (k + 1)) - 1;
      x = 1'b0;
      for (int j = 0; j < len; j++) x ^= ln[off+j];
      cy[k] = x;
      off += len;
    end
    s = '0;
    for (int i = 0; i < nb; i++) s[i] = la[i] ^ lb[i] ^ cy[i];
    s[nb] = cy[nb];
    return s;
  endfunction

  task automatic send7(input logic [6:0] sa, input logic [6:0] sb, input logic sc, output int lat);
    ordy = 1'b1;
    for (int i = 0; i < 20 && !ir; i++) step;
    iv = 1'b1;
    a = sa;
    b = sb;
    ci = sc;
    step;
    iv = 1'b0;
    lat = 0;
    while (!ov && lat < 50) begin
      step;
      lat++;
    end
  endtask

  task automatic test_reset;
    iv = 0; ordy = 0; a = 0; b = 0; ci = 0;
    iv2 = 0; or2 = 0; a2 = 0; b2 = 0; c2 = 0;
    rst = 1'b1;
    step;
    step;
    checks++;
    if (ir !== 1'b0 || ir2 !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", ir, ir2); end
    checks++;
    if (ov !== 1'b0 || ov2 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", ov, ov2); end
    checks++;
    if (n !== '0 || n2 !== '0 || ao !== '0 || bo !== '0 || co !== 1'b0) begin
      fails++; $display("FAIL reset_regs: n=%h n2=%h a_o=%h b_o=%h c_o=%b expected all zero", n, n2, ao, bo, co);
    end
    rst = 1'b0;
    step;
    checks++;
    if (ir !== 1'b1 || ir2 !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b/%b expected 1/1", ir, ir2); end
  endtask

  task automatic test_small_basic;
    int lat;
    logic [7:0] s;
    iv2 = 1; a2 = 2'd3; b2 = 2'd1; c2 = 0; or2 = 1;
    step;
    iv2 = 0;
    lat = 0;
    while (!ov2 && lat < 20) begin step; lat++; end
    checks++;
    if (lat !== 2) begin fails++; $display("FAIL small_latency: got %0d expected 2", lat); end
    checks++;
    if (n2 !== 10'h011) begin fails++; $display("FAIL small_n: got %h expected 011", n2); end
    s = lin_s(2, 7'(ao2), 7'(bo2), co2, 501'(n2));
    checks++;
    if (s !== 8'd4) begin fails++; $display("FAIL small_sum: got %0d expected 4", s); end
    step;
    checks++;
    if (ir2 !== 1'b1 || ov2 !== 1'b0) begin fails++; $display("FAIL small_return_idle: in_ready=%b out_valid=%b expected 1/0", ir2, ov2); end
  endtask

  task automatic test_small_stall;
    int lat;
    logic [7:0] s;
    iv2 = 1; a2 = 2'd3; b2 = 2'd3; c2 = 1; or2 = 0;
    step;
    iv2 = 0;
    lat = 0;
    while (!ov2 && lat < 20) begin step; lat++; end
    checks++;
    if (lat !== 2 || n2 !== 10'h3FF) begin fails++; $display("FAIL stall_n: got %h lat %0d expected 3ff lat 2", n2, lat); end
    s = lin_s(2, 7'(ao2), 7'(bo2), co2, 501'(n2));
    checks++;
    if (s !== 8'd7) begin fails++; $display("FAIL stall_sum: got %0d expected 7", s); end
    for (int i = 0; i < 5; i++) begin
      iv2 = 1; a2 = 2'd1; b2 = 2'd2; c2 = 0;
      step;
      checks++;
      if (ov2 !== 1'b1 || ir2 !== 1'b0 || n2 !== 10'h3FF || ao2 !== 2'd3) begin
        fails++; $display("FAIL stall_hold: out_valid=%b in_ready=%b n=%h a_o=%0d expected 1/0/3ff/3", ov2, ir2, n2, ao2);
      end
    end
    iv2 = 0; or2 = 1;
    step;
    checks++;
    if (ov2 !== 1'b0 || ir2 !== 1'b1) begin fails++; $display("FAIL stall_release: out_valid=%b in_ready=%b expected 0/1", ov2, ir2); end
  endtask

  task automatic test_corners;
    int lat;
    send7(7'h00, 7'h00, 1'b0, lat);
    checks++;
    if (lat !== 7) begin fails++; $display("FAIL zero_latency: got %0d expected 7", lat); end
    checks++;
    if (n !== '0) begin fails++; $display("FAIL zero_n: got %h expected 0", n); end
    step;
    send7(7'h7F, 7'h7F, 1'b1, lat);
    checks++;
    if (n !== '1 || lat !== 7) begin fails++; $display("FAIL ones_n: got %h lat %0d expected all ones lat 7", n, lat); end
    checks++;
    if (lin_s(7, ao, bo, co, n) !== 8'd255) begin fails++; $display("FAIL ones_sum: got %0d expected 255", lin_s(7, ao, bo, co, n)); end
    step;
  endtask

  task automatic test_random;
    localparam int NR = 1500;
    int sent, got, cyc;
    logic [14:0] q[$];
    logic [14:0] e;
    logic [6:0] na, nb;
    logic nc;
    logic [7:0] gs;
    sent = 0; got = 0; cyc = 0;
    na = 7'($urandom); nb = 7'($urandom); nc = 1'($urandom);
    while ((sent < NR || q.size() > 0) && cyc < 80000) begin
      iv = (sent < NR) && ($urandom % 4 != 0);
      a = na; b = nb; ci = nc;
      ordy = ($urandom % 3 != 0);
      if (ov && ordy) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rand_spurious: result with no pending operands");
        end else begin
          e = q.pop_front();
          got++;
          checks++;
          if ({ao, bo, co} !== e) begin fails++; $display("FAIL rand_operands: got %h expected %h", {ao, bo, co}, e); end
          checks++;
          if (n !== ref_n(e[14:8], e[7:1], e[0])) begin fails++; $display("FAIL rand_n: got %h expected %h", n, ref_n(e[14:8], e[7:1], e[0])); end
          gs = 8'(e[14:8]) + 8'(e[7:1]) + 8'(e[0]);
          checks++;
          if (lin_s(7, ao, bo, co, n) !== gs) begin fails++; $display("FAIL rand_sum: got %0d expected %0d", lin_s(7, ao, bo, co, n), gs); end
        end
      end
      if (iv && ir) begin
        q.push_back({na, nb, nc});
        sent++;
        na = 7'($urandom); nb = 7'($urandom); nc = 1'($urandom);
      end
      step;
      cyc++;
    end
    iv = 0;
    checks++;
    if (got !== NR || q.size() != 0) begin fails++; $display("FAIL rand_count: got %0d results pending %0d expected %0d/0", got, q.size(), NR); end
    ordy = 1;
    for (int i = 0; i < 12 && !ir; i++) step;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [6:0] ra, rb;
    ordy = 1; iv = 1; a = 7'h55; b = 7'h2A; ci = 1;
    step;
    iv = 0;
    step; step; step;
    rst = 1'b1;
    step;
    checks++;
    if (ov !== 1'b0 || n !== '0 || ao !== '0 || ir !== 1'b0) begin
      fails++; $display("FAIL midreset: out_valid=%b n=%h a_o=%h in_ready=%b expected 0/0/0/0", ov, n, ao, ir);
    end
    rst = 1'b0;
    step;
    checks++;
    if (ir !== 1'b1 || ov !== 1'b0) begin fails++; $display("FAIL midreset_idle: in_ready=%b out_valid=%b expected 1/0", ir, ov); end
    ra = 7'($urandom); rb = 7'($urandom);
    send7(ra, rb, 1'b1, lat);
    checks++;
    if (lat !== 7 || n !== ref_n(ra, rb, 1'b1)) begin
      fails++; $display("FAIL midreset_next: lat %0d n=%h expected 7 %h", lat, n, ref_n(ra, rb, 1'b1));
    end
    step;
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int cyc;
    logic bad;
    bad = 1'b0;
    cyc = 0;
    iv = 1; ordy = 1;
    while (acc.size() < 5 && cyc < 100) begin
      if (ov && ir) bad = 1'b1;
      if (iv && ir) begin
        acc.push_back(cyc);
        a = 7'($urandom); b = 7'($urandom); ci = 1'($urandom);
      end
      step;
      cyc++;
    end
    iv = 0;
    checks++;
    if (acc.size() != 5 || bad) begin fails++; $display("FAIL b2b_accepts: got %0d accepts overlap %b expected 5/0", acc.size(), bad); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 9) begin fails++; $display("FAIL b2b_spacing: got %0d expected 9", acc[i] - acc[i-1]); end
    end
    for (int i = 0; i < 12 && !ir; i++) step;
  endtask

  initial begin
    test_reset;
    test_small_basic;
    test_small_stall;
    test_corners;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
